// File: rtl/proc_pkg.sv
// Shared constants for the processor control unit: opcodes, time-step
// encoding and the III/XXX/YYY field positions of the 9-bit instruction.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    localparam int FIELD_W = 3;
    localparam int OP_MSB  = 8;
    localparam int X_MSB   = 5;
    localparam int Y_MSB   = 2;

endpackage

// File: rtl/proc_ctrl.sv
// Multi-cycle control unit: fetches III XXX YYY instructions and sequences
// T0..T3 strobes. Define PROC_CTRL_MVNZ_EN to enable the mvnz opcode (100).
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int DIN_W = 9,
    parameter int OP_W  = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic [DIN_W-1:0] DIN,
    input  logic             G_nz,
    output logic             IRin,
    output logic [OP_W-1:0]  rin_idx,
    output logic             rin_en,
    output logic [OP_W-1:0]  rout_idx,
    output logic             rout_en,
    output logic             Ain,
    output logic             Gin,
    output logic             Gout,
    output logic             DINout,
    output logic             AddSub,
    output logic             Done
);

    tstep_e           state_q, state_d;
    logic [DIN_W-1:0] ir_q;
    logic [OP_W-1:0]  opcode, fieldX, fieldY;

    assign opcode = ir_q[OP_MSB -: FIELD_W];
    assign fieldX = ir_q[X_MSB -: FIELD_W];
    assign fieldY = ir_q[Y_MSB -: FIELD_W];

`ifndef PROC_CTRL_MVNZ_EN
    logic unusedGnz;
    assign unusedGnz = G_nz;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (IRin) begin
                ir_q <= DIN;
            end
        end
    end

    // Idx outputs stay 0 whenever their enable is 0, so each branch sets both.
    always_comb begin
        state_d  = state_q;
        IRin     = 1'b0;
        rin_idx  = '0;
        rin_en   = 1'b0;
        rout_idx = '0;
        rout_en  = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        Gout     = 1'b0;
        DINout   = 1'b0;
        AddSub   = 1'b0;
        Done     = 1'b0;
        case (state_q)
            T0: begin
                IRin = Run;
                if (Run) begin
                    state_d = T1;
                end
            end
            T1: begin
                state_d = T0;
                case (opcode)
                    OP_MV: begin
                        rout_idx = fieldY;
                        rout_en  = 1'b1;
                        rin_idx  = fieldX;
                        rin_en   = 1'b1;
                        Done     = 1'b1;
                    end
                    OP_MVI: begin
                        DINout  = 1'b1;
                        rin_idx = fieldX;
                        rin_en  = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_idx = fieldX;
                        rout_en  = 1'b1;
                        Ain      = 1'b1;
                        state_d  = T2;
                    end
`ifdef PROC_CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        rout_idx = fieldY;
                        rout_en  = 1'b1;
                        rin_idx  = G_nz ? fieldX : '0;
                        rin_en   = G_nz;
                        Done     = 1'b1;
                    end
`endif
                    default: begin
                        Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                rout_idx = fieldY;
                rout_en  = 1'b1;
                Gin      = 1'b1;
                AddSub   = opcode[0];
                state_d  = T3;
            end
            T3: begin
                Gout    = 1'b1;
                rin_idx = fieldX;
                rin_en  = 1'b1;
                Done    = 1'b1;
                state_d = T0;
            end
            default: begin
                state_d = T0;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: directed vector table followed by
// random instruction streams compared against a per-instruction step model.
module tb_proc_ctrl;

    typedef struct packed {
        logic       irin;
        logic [2:0] rinIdx;
        logic       rinEn;
        logic [2:0] routIdx;
        logic       routEn;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic       addsub;
        logic       done;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       run;
        logic [8:0] din;
        logic       gnz;
        outs_t      exp;
    } vec_t;

    typedef struct {
        logic [2:0] op;
        logic [2:0] x;
        logic [2:0] y;
        int         k;
    } step_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic [8:0] DIN = '0;
    logic       G_nz = 1'b0;
    logic       IRin, rin_en, rout_en, Ain, Gin, Gout, DINout, AddSub, Done;
    logic [2:0] rin_idx, rout_idx;
    outs_t      dutOut;

    int    total = 0;
    int    bad = 0;
    int    cycle = 0;
    step_t pend[$];
    vec_t  vecs[22];

    proc_ctrl dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .G_nz(G_nz),
        .IRin(IRin), .rin_idx(rin_idx), .rin_en(rin_en),
        .rout_idx(rout_idx), .rout_en(rout_en), .Ain(Ain), .Gin(Gin),
        .Gout(Gout), .DINout(DINout), .AddSub(AddSub), .Done(Done)
    );

    always #5 Clock = ~Clock;

    assign dutOut = {IRin, rin_idx, rin_en, rout_idx, rout_en,
                     Ain, Gin, Gout, DINout, AddSub, Done};

    function automatic outs_t mk(logic irin, logic [2:0] ri, logic re,
                                 logic [2:0] ro, logic oe, logic a, logic g,
                                 logic go, logic dout, logic asb, logic dn);
        return {irin, ri, re, ro, oe, a, g, go, dout, asb, dn};
    endfunction

    // Expected strobes for step k of an instruction (k=0 is the decode cycle).
    function automatic outs_t stepOut(logic [2:0] op, logic [2:0] x,
                                      logic [2:0] y, int k, logic gnz);
        outs_t o = '0;
        if (k == 0) begin
            if (op == 3'd0) begin
                o.routIdx = y; o.routEn = 1; o.rinIdx = x; o.rinEn = 1; o.done = 1;
            end else if (op == 3'd1) begin
                o.dinout = 1; o.rinIdx = x; o.rinEn = 1; o.done = 1;
            end else if (op == 3'd2 || op == 3'd3) begin
                o.routIdx = x; o.routEn = 1; o.ain = 1;
`ifdef PROC_CTRL_MVNZ_EN
            end else if (op == 3'd4) begin
                o.routIdx = y; o.routEn = 1; o.done = 1;
                o.rinEn = gnz; o.rinIdx = gnz ? x : 3'd0;
`endif
            end else begin
                o.done = 1;
            end
        end else if (k == 1) begin
            o.routIdx = y; o.routEn = 1; o.gin = 1; o.addsub = op[0];
        end else begin
            o.gout = 1; o.rinIdx = x; o.rinEn = 1; o.done = 1;
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%b want=%b", name, cycle, act, exp);
        end
    endtask

    // One clock: drive at negedge, check settled outputs, advance the model.
    task automatic applyStimulus(input logic rst, input logic run, input logic [8:0] din,
                                 input logic gnz, input logic useTab, input outs_t tabExp);
        outs_t exp;
        int    nSteps;
        @(negedge Clock);
        Reset = rst; Run = run; DIN = din; G_nz = gnz;
        cycle++;
        #1;
        if (pend.size() == 0) begin
            exp = '0;
            exp.irin = run;
        end else begin
            exp = stepOut(pend[0].op, pend[0].x, pend[0].y, pend[0].k, gnz);
        end
        checkOutput("model", dutOut, exp);
        if (useTab) checkOutput("vector", dutOut, tabExp);
        if (rst) begin
            pend.delete();
        end else if (pend.size() == 0) begin
            if (run) begin
                nSteps = (din[8:6] == 3'd2 || din[8:6] == 3'd3) ? 3 : 1;
                for (int k = 0; k < nSteps; k++) begin
                    pend.push_back('{din[8:6], din[5:3], din[2:0], k});
                end
            end
        end else begin
            void'(pend.pop_front());
        end
    endtask

    initial begin
        outs_t z = '0;
        outs_t mvnzLo, mvnzHi;
`ifdef PROC_CTRL_MVNZ_EN
        mvnzLo = mk(0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 1);
        mvnzHi = mk(0, 4, 1, 2, 1, 0, 0, 0, 0, 0, 1);
`else
        mvnzLo = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        mvnzHi = mvnzLo;
`endif
        vecs[0]  = '{0, 0, 9'b000_000_000, 0, z};
        vecs[1]  = '{0, 1, 9'b001_011_000, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{0, 0, 9'b001_011_000, 0, mk(0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1)};
        vecs[3]  = '{0, 1, 9'b000_010_101, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{0, 0, 9'b000_010_101, 0, mk(0, 2, 1, 5, 1, 0, 0, 0, 0, 0, 1)};
        vecs[5]  = '{0, 1, 9'b011_001_110, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[6]  = '{0, 1, 9'b000_000_000, 0, mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
        vecs[7]  = '{0, 1, 9'b000_111_111, 0, mk(0, 0, 0, 6, 1, 0, 1, 0, 0, 1, 0)};
        vecs[8]  = '{0, 0, 9'b111_111_111, 0, mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1)};
        vecs[9]  = '{0, 1, 9'b001_011_000, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[10] = '{0, 1, 9'b010_101_011, 0, mk(0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1)};
        vecs[11] = '{0, 1, 9'b010_101_011, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[12] = '{0, 0, 9'b000_000_000, 0, mk(0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0)};
        vecs[13] = '{1, 0, 9'b000_000_000, 0, mk(0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0)};
        vecs[14] = '{0, 0, 9'b011_111_111, 0, z};
        vecs[15] = '{0, 0, 9'b000_000_000, 0, z};
        vecs[16] = '{0, 1, 9'b100_100_010, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[17] = '{0, 0, 9'b100_100_010, 0, mvnzLo};
        vecs[18] = '{0, 1, 9'b100_100_010, 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[19] = '{0, 0, 9'b100_100_010, 1, mvnzHi};
        vecs[20] = '{0, 1, 9'b111_000_000, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[21] = '{0, 0, 9'b111_000_000, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};

        // Bring the DUT out of its unknown power-up state before checking.
        repeat (2) @(posedge Clock);
        pend.delete();

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].run, vecs[i].din, vecs[i].gnz, 1'b1, vecs[i].exp);
        end

        for (int i = 0; i < 3000; i++) begin
            logic rst, run;
            rst = ($urandom_range(0, 39) == 0);
            run = rst ? 1'b0 : ($urandom_range(0, 9) < 7);
            applyStimulus(rst, run, 9'($urandom), 1'($urandom), 1'b0, '0);
            total++;
            if ((32'(rout_en) + 32'(DINout) + 32'(Gout)) > 1) begin
                bad++;
                $display("[TB] FAIL busDriver cycle=%0d got=%b%b%b want=at most one",
                         cycle, rout_en, DINout, Gout);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
